// File: rtl/arm_pkg.sv
// Shared definitions for the ARM32 fetch unit.
//   ARCH          - datapath width.
//   RESET_PC      - byte address of the first fetch after reset.
//   fetch_state_t - fetch FSM states.
//   fetch_entry_t - one prefetch entry: instruction word plus its PC.
package arm_pkg;

  localparam int ARCH = 32;

  localparam logic [ARCH-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [ARCH-1:0] data;
    logic [ARCH-1:0] pc;
  } fetch_entry_t;

  // Forces a byte address onto a word boundary.
  function automatic logic [ARCH-1:0] word_align(input logic [ARCH-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/arm_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   mem_*  - request/grant plus one-cycle-later read response.
//   ins_*  - valid/ready instruction handshake towards decode.
// Modports:
//   master - the fetch unit.
//   slave  - memory and decode (the environment).
interface arm_fetch_unit_if;
  import arm_pkg::*;

  logic            mem_req;
  logic [ARCH-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [ARCH-1:0] mem_rdata;

  logic            ins_valid;
  logic            ins_ready;
  logic [ARCH-1:0] ins_data;
  logic [ARCH-1:0] ins_pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ins_valid, ins_data, ins_pc,
    input  ins_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ins_valid, ins_data, ins_pc,
    output ins_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t.
//   clk, reset_n - clock, synchronous active-low reset.
//   clear        - empties the FIFO; wins over push and pop.
//   push/push_entry - write one entry (accepted when not full, or full with pop).
//   pop          - remove the head entry (ignored when empty).
//   head_entry   - current head; all zeros while empty.
//   count/empty/full - occupancy.
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  push_entry,
  output fetch_entry_t  head_entry,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  // Zero head while empty so the outputs are clean after reset or a flush.
  assign head_entry = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    // A full FIFO may still take a push when the head leaves in the same cycle.
    do_push  = push & (~full | pop);
    do_pop   = pop & ~empty;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction fetch stage for the ARM32 processor.
//   clk, reset_n    - clock, synchronous active-low reset.
//   redirect_valid  - taken branch; restart fetching at redirect_pc.
//   redirect_pc     - new PC (low two bits ignored).
//   halt            - level; stops new memory requests, FIFO keeps draining.
//   bus (master)    - memory request/response and decode handshake.
// Requests are issued only while the FIFO has room for every response that
// could still come back (count + outstanding < FIFO_DEPTH).
module arm_fetch_unit
  import arm_pkg::*;
#(
  parameter logic [ARCH-1:0] RESET_PC   = arm_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     redirect_valid,
  input  logic [ARCH-1:0]          redirect_pc,
  input  logic                     halt,
  arm_fetch_unit_if.master         bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [ARCH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ARCH-1:0] inflight_pc_q, inflight_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            discard_q, discard_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_push;
  logic            fifo_pop;
  logic            credit_ok;
  logic            mem_accept;
  logic            rsp_valid;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign credit_ok  = (32'(fifo_count) + 32'(outstanding_q)) < 32'(FIFO_DEPTH);

  // Request depends only on registered state plus halt/redirect, never on rvalid.
  assign bus.mem_req  = (state_q == RUN) & ~halt & ~redirect_valid & credit_ok;
  assign bus.mem_addr = fetch_pc_q;
  assign mem_accept   = bus.mem_req & bus.mem_gnt;

  // A response counts only if we are waiting for one and it is not stale.
  // The outstanding gate also drops a response to a request issued just
  // before reset.
  assign rsp_valid  = bus.mem_rvalid & outstanding_q & ~discard_q & ~redirect_valid;
  assign fifo_pop   = ~fifo_empty & bus.ins_ready & ~redirect_valid;
  assign fifo_push  = rsp_valid & (~fifo_full | fifo_pop);
  assign push_entry = '{data: bus.mem_rdata, pc: inflight_pc_q};

  assign bus.ins_valid = ~fifo_empty;
  assign bus.ins_data  = head_entry.data;
  assign bus.ins_pc    = head_entry.pc;

  // FSM next state; a halt arriving with a redirect still lands in HALTED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // PC, in-flight tracking and stale-response discard.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    outstanding_d = outstanding_q;
    // Covers the cycle after a redirect; the redirect cycle itself is
    // blocked directly in rsp_valid.
    discard_d     = redirect_valid & outstanding_q;

    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (mem_accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (mem_accept) begin
      inflight_pc_d = fetch_pc_q;
    end

    // A new acceptance wins over the response of the previous one.
    if (mem_accept) begin
      outstanding_d = 1'b1;
    end else if (bus.mem_rvalid) begin
      outstanding_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (redirect_valid),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

endmodule

// File: doc/arm_fetch_unit.md
# arm_fetch_unit

Instruction fetch stage that sits directly upstream of the ARM32 `processor` decode/execute logic. It generates word-aligned fetch addresses, issues read requests to instruction memory, and buffers returned words in a small prefetch FIFO. It presents each instruction and its PC to decode over a valid/ready handshake. Branch redirects from execute flush the buffer and discard in-flight responses; a halt input stops fetching.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetch; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 4: prefetch entries; power of two, ≥ 2.
- `clk` input 1: clock; all state updates on posedge.
- `reset_n` input 1: reset, synchronous, active-low.
- `mem_req` output 1: fetch request valid.
- `mem_addr` output 32: byte address of the request, always word aligned.
- `mem_gnt` input 1: memory accepts the request this cycle.
- `mem_rvalid` input 1: response valid; exactly 1 cycle after the accepting cycle, in order.
- `mem_rdata` input 32: instruction word.
- `redirect_valid` input 1: branch taken; restart fetching at `redirect_pc`.
- `redirect_pc` input 32: new PC; bits [1:0] are ignored and forced to 0.
- `halt` input 1: level; stop issuing new requests (driven from `trap`).
- `ins_valid` output 1: `ins_data`/`ins_pc` hold a valid instruction.
- `ins_ready` input 1: decode accepts the instruction this cycle.
- `ins_data` output 32: instruction word.
- `ins_pc` output 32: byte address of `ins_data`.

## Operation
- States: BOOT, RUN, HALTED.
  - BOOT: entered on reset; no request. Moves to RUN on the next edge.
  - RUN: `mem_req` = 1 when `halt`=0, no redirect this cycle, and `count + outstanding < FIFO_DEPTH`.
  - RUN → HALTED when `halt`=1. HALTED → RUN when `halt`=0.
  - The FIFO keeps draining to decode while HALTED.
- `fetch_pc` advances by 4 on each accepted request (`mem_req & mem_gnt`). It wraps 32'hFFFF_FFFC → 0.
- `outstanding` (0 or 1) is set on acceptance and cleared on `mem_rvalid`.
- A response is pushed as `{rdata, pc}`. The pc of each in-flight request is captured when the request is accepted.
- Redirect, with priority over everything else in the same cycle:
  - FIFO cleared.
  - `fetch_pc` ← `{redirect_pc[31:2], 2'b00}`.
  - `mem_req` forced to 0 that cycle.
  - Any response arriving in the redirect cycle or the following cycle for a pre-redirect request is discarded, using a discard flag set when `outstanding`=1 at redirect.
  - The instruction on `ins_*` in the redirect cycle is not consumed, even if `ins_ready`=1.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Push to a full FIFO cannot occur, because the credit check prevents it. The bench asserts this.
- `ins_valid` = FIFO not empty. `ins_data`/`ins_pc` = head entry, stable while `ins_valid & ~ins_ready`.
- `halt` and `redirect_valid` together: the redirect is applied and the state goes to HALTED.

## Timing
- Reset values:
  - `mem_req` = 0, `mem_addr` = `RESET_PC`.
  - `ins_valid` = 0, `ins_data` = 0, `ins_pc` = 0.
  - FIFO empty, `outstanding` = 0, state BOOT.
- Reset asserted mid-operation discards all FIFO and in-flight state. Responses arriving in the cycle after reset are ignored.
- First request: the first cycle after reset release is BOOT; `mem_req` = 1 on the second cycle.
- Latency from request accepted in cycle N:
  - `mem_rvalid` in N+1.
  - `ins_valid` in N+2 (registered FIFO, no bypass).
- Throughput: 1 instruction/cycle sustained with `mem_gnt`=1 and `ins_ready`=1.
- Redirect in cycle R: the first new request is issued at R+1 with `mem_addr` = `redirect_pc`; the earliest matching `ins_valid` is R+3.
- `mem_req`/`mem_addr` are combinational from registered state and `redirect_valid`/`halt`. There is no combinational path from `mem_rvalid` to `mem_req`.

## Structure
- Shared package `arm_pkg`:
  - `ARCH` = 32.
  - `RESET_PC`.
  - `fetch_state_t` enum {BOOT, RUN, HALTED}.
  - `fetch_entry_t` struct {data[31:0], pc[31:0]}.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`.
  - Parameter `DEPTH`.
  - Ports `push`, `pop`, `clear`, `count`, `empty`, `full`.
  - `clear` has priority over push/pop.
- `arm_fetch_unit` holds the FSM, PC, credit and discard logic (≈200 lines total).

## Test plan
- Reset then free run (`gnt`=1, `ready`=1, memory word = address): `mem_addr` 0, 4, 8, …; `ins_pc`=0 with `ins_data`=0 appears 3 cycles after reset release, then one instruction per cycle.
- Backpressure (`ins_ready`=0 for 10 cycles): exactly 4 entries are buffered, `mem_req` drops to 0, `ins_*` stays stable; on release, PCs 0, 4, 8, 12, 16 are delivered in order with none lost.
- Redirect to 32'h0000_0103 while a request is in flight: the stale response is dropped, the next `mem_addr` = 32'h100, and the next delivered `ins_pc` = 32'h100.
- Wrap: `redirect_pc` = 32'hFFFF_FFF8 gives delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `halt`=1 for 5 cycles: no `mem_req`, the FIFO drains to empty, `ins_valid` = 0; after release, fetching resumes at the next sequential PC.
- `mem_gnt` toggling 1/0 with random `ins_ready`: the delivered PC sequence is strictly +4 with no duplicates or gaps.
